pattern_predictor_2bit: RTL and testbench

A 1-bit pattern (branch-style) predictor built on a 2-bit saturating counter. Each clock it samples `actual_pattern` and compares it with the registered prediction. It flags a match and updates the counter, and it keeps 8-bit tallies of total samples and correct predictions. It sits as a standalone statistics/prediction block fed by a serial bit stream.

---
 rtl/pattern_predictor_2bit.sv | 50 +++++
 tb/tb_pattern_predictor_2bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pattern_predictor_2bit.sv
// 1-bit pattern predictor built on a 2-bit saturating counter, with
// running tallies of samples taken and correct predictions.
module pattern_predictor_2bit #(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rst,
    input  logic       actual_pattern,
    output logic [7:0] x_cnt,
    output logic       predicted_patter,
    output logic       z_match,
    output logic [7:0] z_cnt
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0] z_cnt_q, z_cnt_d;
    logic             clear;

    // Soft clear (rst low) has the same effect as the hard reset.
    assign clear            = reset || !rst;
    assign predicted_patter = state_q[1];
    assign z_match          = (state_q[1] == actual_pattern);
    assign x_cnt            = x_cnt_q;
    assign z_cnt            = z_cnt_q;

    always_comb begin
        state_d = state_q;
        x_cnt_d = x_cnt_q + 1'b1;
        z_cnt_d = z_match ? z_cnt_q + 1'b1 : z_cnt_q;
        if (actual_pattern && state_q != 2'b11)
            state_d = state_q + 2'd1;
        else if (!actual_pattern && state_q != 2'b00)
            state_d = state_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= 2'b00;
            x_cnt_q <= '0;
            z_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            x_cnt_q <= x_cnt_d;
            z_cnt_q <= z_cnt_d;
        end
    end

endmodule

// File: tb/tb_pattern_predictor_2bit.sv
// Scoreboard bench for pattern_predictor_2bit: a behavioural model predicts
// each post-edge result, which is queued at drive time and compared after the edge.
module tb_pattern_predictor_2bit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rst = 1'b1;
    logic       actual_pattern = 1'b0;
    logic [7:0] x_cnt;
    logic       predicted_patter;
    logic       z_match;
    logic [7:0] z_cnt;

    typedef struct {
        logic       pred;
        logic [7:0] x;
        logic [7:0] z;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [1:0] m_s = 2'b00;
    logic [7:0] m_x = 8'd0;
    logic [7:0] m_z = 8'd0;

    pattern_predictor_2bit dut (
        .clk              (clk),
        .reset            (reset),
        .rst              (rst),
        .actual_pattern   (actual_pattern),
        .x_cnt            (x_cnt),
        .predicted_patter (predicted_patter),
        .z_match          (z_match),
        .z_cnt            (z_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs away from the edge, check the combinational match,
    // advance the model, then compare registered outputs after the edge.
    task automatic cycle(input logic r, input logic s, input logic ap);
        exp_t e, got;
        @(negedge clk);
        reset = r;
        rst = s;
        actual_pattern = ap;
        #1;
        chk("z_match", z_match, (m_s[1] == ap));
        if (r || !s) begin
            m_s = 2'b00;
            m_x = 8'd0;
            m_z = 8'd0;
        end else begin
            if (m_s[1] == ap) m_z = m_z + 8'd1;
            m_x = m_x + 8'd1;
            if (ap && m_s != 2'b11) m_s = m_s + 2'd1;
            else if (!ap && m_s != 2'b00) m_s = m_s - 2'd1;
        end
        e.pred = m_s[1];
        e.x = m_x;
        e.z = m_z;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            chk("pred", predicted_patter, got.pred);
            chk("x_cnt", x_cnt, got.x);
            chk("z_cnt", z_cnt, got.z);
        end
    endtask

    initial begin
        // Reset: second cycle drives a 1 so z_match must read 0.
        cycle(1, 1, 0);
        cycle(1, 1, 1);
        chk("rst_pred", predicted_patter, 0);
        chk("rst_x", x_cnt, 0);
        chk("rst_z", z_cnt, 0);
        chk("rst_match1", z_match, 0);

        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        chk("zeros_x", x_cnt, 3);
        chk("zeros_z", z_cnt, 3);

        cycle(0, 1, 1);
        chk("one1_pred", predicted_patter, 0);
        cycle(0, 1, 1);
        chk("one2_pred", predicted_patter, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1);
        chk("ones_x", x_cnt, 11);
        chk("ones_z", z_cnt, 9);

        cycle(0, 1, 0);
        chk("dn1_pred", predicted_patter, 1);
        cycle(0, 1, 0);
        chk("dn2_pred", predicted_patter, 0);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0);
        chk("dn_x", x_cnt, 15);
        chk("dn_z", z_cnt, 11);

        // Soft clear from S=11 with nonzero counters.
        for (int i = 0; i < 3; i++) cycle(0, 1, 1);
        chk("pre_clr_pred", predicted_patter, 1);
        cycle(0, 0, 1);
        chk("sclr_pred", predicted_patter, 0);
        chk("sclr_x", x_cnt, 0);
        chk("sclr_z", z_cnt, 0);
        // S must be 00: two more 1s needed before prediction flips.
        cycle(0, 1, 1);
        chk("sclr_s_pred", predicted_patter, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1);
        cycle(1, 0, 1);
        chk("both_pred", predicted_patter, 0);
        chk("both_x", x_cnt, 0);
        chk("both_z", z_cnt, 0);

        // Counter wrap.
        cycle(1, 1, 0);
        for (int i = 0; i < 255; i++) cycle(0, 1, 0);
        chk("w255_x", x_cnt, 255);
        chk("w255_z", z_cnt, 255);
        cycle(0, 1, 0);
        chk("w256_x", x_cnt, 0);
        chk("w256_z", z_cnt, 0);
        cycle(0, 1, 0);
        chk("w257_x", x_cnt, 1);
        chk("w257_z", z_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
